count_snapshot_buf: RTL and testbench
=====================================

// Module: count_snapshot_buf
// PURPOSE
//   Downstream consumer of the 4-bit up-counter (clk/reset/enable/count).
//   Tracks counter wrap-around to form an extended count {ext,count} and
//   captures snapshots of it on a sample strobe into a small FIFO.
//   The FIFO drains over a valid/ready interface to the logging/readout stage.
// PARAMETERS
//   CNT_W   4  width of incoming counter value
//   EXT_W   4  width of wrap-extension field (wraps modulo 2^EXT_W)
//   DEPTH   4  FIFO entries; power of two, >= 2
//   ADDR_W  2  log2(DEPTH)
// PORTS
//   clk        in   1             rising-edge clock
//   reset      in   1             synchronous, active-high
//   enable     in   1             counter enable (same signal driving counter)
//   count      in   CNT_W         counter output
//   sample     in   1             capture request, one snapshot per high cycle
//   out_ready  in   1             consumer ready
//   clear_ovf  in   1             clears sticky overflow
//   out_valid  out  1             head entry valid
//   out_data   out  CNT_W+EXT_W   {ext,count} snapshot at FIFO head
//   level      out  ADDR_W+1      entries held, 0..DEPTH
//   full       out  1             level == DEPTH
//   empty      out  1             level == 0
//   overflow   out  1             sticky: a sample was dropped while full
// BEHAVIOUR
//   - Reset (sync, high): prev_count=0, ext=0, FIFO flushed (rd/wr ptr=0),
//     level=0, empty=1, full=0, out_valid=0, out_data=0, overflow=0.
//     Reset mid-operation discards all stored entries; no drain.
//   - Wrap detect: wrap = (prev_count == all-ones) && (count == 0).
//     prev_count <= count every cycle (regardless of enable); X on count
//     while reset asserted is not sampled (prev_count held at 0).
//   - Counter reset (count -> 0 from non-max value) is NOT a wrap; ext holds.
//   - ext <= ext + wrap, modulo 2^EXT_W (EXT_W all-ones + wrap -> 0).
//   - Snapshot value = {ext + wrap, count}: wrap in the sample cycle counted.
//   - Push = sample && gate_ok && (!full || pop). gate_ok per CONFIGURATION.
//   - Pop  = out_valid && out_ready.
//   - Latency: push in cycle N -> out_valid/out_data in cycle N+1; no
//     fall-through. out_data stable while out_valid && !out_ready.
//   - Simultaneous push+pop: level unchanged; when full, push accepted
//     because pop frees the slot the same cycle.
//   - Push+pop when level==1: new entry becomes head in next cycle.
//   - Drop: sample && gate_ok && full && !pop -> entry discarded,
//     overflow <= 1. clear_ovf clears it; drop in same cycle wins (stays 1).
//   - Pointers wrap modulo DEPTH; full/empty derived from level.
//   - out_data when empty: holds last driven value (don't-care to consumer).
// CONFIGURATION
//   CAPTURE_GATE_EN defined: gate_ok = enable; sample ignored (no push, no
//     drop, overflow unaffected) while enable low.
//   CAPTURE_GATE_EN undefined: gate_ok = 1; sample captured regardless of
//     enable. Wrap tracking is identical in both builds.
// TESTING
//   1 reset=1 3 cycles, count=X -> out_valid=0, level=0, empty=1,
//     overflow=0; after release, first sample at count=4'h3 -> out_data=8'h03.
//   2 count 4'hE,4'hF,4'h0 with enable=1, sample at 4'h0 -> out_data=8'h10;
//     count 4'h5 -> 4'h0 (counter reset) then sample -> out_data=8'h10.
//   3 out_ready=0, 5 consecutive samples (DEPTH=4) -> full=1 after 4th,
//     overflow=1 after 5th; then out_ready=1 drains 4 entries in order.
//   4 full, sample=1 and out_ready=1 same cycle -> level stays 4,
//     overflow stays 0, head advances by one.
//   5 16 wraps with EXT_W=4 -> ext returns to 0; sample at count=4'h0
//     after 16th wrap -> out_data=8'h00.
//   6 enable=0, sample=1: with CAPTURE_GATE_EN level unchanged; without
//     it level+1. Reset asserted with level=3 -> level=0 next cycle.

Source files
------------

// File: rtl/count_snapshot_buf.sv
// ============================================================================
// count_snapshot_buf
// ----------------------------------------------------------------------------
// Purpose
//   This block sits downstream of a small free-running up-counter. It watches
//   the counter for wrap-around (all-ones -> zero) and keeps a wrap-extension
//   field 'ext', which together with the counter forms the value {ext,count}.
//   Each cycle that 'sample' is high, one snapshot of {ext,count} goes into a
//   small FIFO. The FIFO drains to a readout stage over a valid/ready
//   interface.
//
// Build option
//   CAPTURE_GATE_EN  When this macro is defined, a sample is only taken while
//                    'enable' is high. While 'enable' is low the sample is
//                    ignored: nothing is pushed, nothing is dropped, and the
//                    overflow flag does not change. When the macro is not
//                    defined, samples are taken whatever the value of
//                    'enable'. Wrap tracking is the same in both builds.
//
// Ports
//   clk        in   1             rising-edge clock
//   reset      in   1             synchronous, active-high reset
//   enable     in   1             counter enable (same net as the counter's)
//   count      in   CNT_W         counter value
//   sample     in   1             capture request, one snapshot per high cycle
//   out_ready  in   1             consumer ready
//   clear_ovf  in   1             clears the sticky overflow flag
//   out_valid  out  1             head entry valid
//   out_data   out  CNT_W+EXT_W   {ext,count} snapshot at the FIFO head
//   level      out  ADDR_W+1      number of entries held, 0..DEPTH
//   full       out  1             level == DEPTH
//   empty      out  1             level == 0
//   overflow   out  1             sticky: a sample was dropped while full
// ============================================================================
module count_snapshot_buf #(
    parameter int CNT_W  = 4,
    parameter int EXT_W  = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [CNT_W-1:0]         count,
    input  logic                     sample,
    input  logic                     out_ready,
    input  logic                     clear_ovf,
    output logic                     out_valid,
    output logic [CNT_W+EXT_W-1:0]   out_data,
    output logic [ADDR_W:0]          level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int              DATA_W    = CNT_W + EXT_W;
    localparam logic [ADDR_W:0] LEVEL_MAX = (ADDR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]  r_prev_count;
    logic [EXT_W-1:0]  r_ext;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_overflow;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic              w_wrap;
    logic [EXT_W-1:0]  w_ext_now;
    logic [DATA_W-1:0] w_snap;
    logic              w_gate_ok;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [ADDR_W-1:0] w_wr_ptr_next;
    logic [ADDR_W-1:0] w_rd_ptr_next;
    logic [ADDR_W:0]   w_level_next;
    logic [DATA_W-1:0] w_head_next;
    logic              w_overflow_next;
    logic [DEPTH-1:0]  w_wr_en;

    // ------------------------------------------------------------------------
    // Capture gating
    // ------------------------------------------------------------------------
`ifdef CAPTURE_GATE_EN
    assign w_gate_ok = enable;
`else
    // In this build 'enable' has no effect on capture. The net is kept
    // connected so that the port list is the same in both builds.
    logic w_unused_enable;
    assign w_unused_enable = enable;
    assign w_gate_ok       = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Wrap tracking
    // A wrap is only the step from all-ones to zero. A counter reset from any
    // other value to zero is not a wrap. The snapshot adds the current wrap
    // into ext, so a sample taken in the wrap cycle already shows it.
    // ------------------------------------------------------------------------
    assign w_wrap    = (r_prev_count == {CNT_W{1'b1}}) && (count == '0);
    assign w_ext_now = r_ext + EXT_W'(w_wrap);
    assign w_snap    = {w_ext_now, count};

    // ------------------------------------------------------------------------
    // FIFO control
    // full and empty are decoded from level. When the FIFO is full, a push
    // is still accepted if a pop frees a slot in the same cycle.
    // ------------------------------------------------------------------------
    assign w_full  = (r_level == LEVEL_MAX);
    assign w_empty = (r_level == '0);
    assign w_pop   = r_out_valid && out_ready;
    assign w_push  = sample && w_gate_ok && (!w_full || w_pop);
    assign w_drop  = sample && w_gate_ok && w_full && !w_pop;

    // DEPTH is a power of two, so the pointers wrap on their natural width.
    assign w_wr_ptr_next = w_push ? r_wr_ptr + ADDR_W'(1) : r_wr_ptr;
    assign w_rd_ptr_next = w_pop  ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + (ADDR_W + 1)'(1);
            2'b01:   w_level_next = r_level - (ADDR_W + 1)'(1);
            default: w_level_next = r_level;
        endcase
    end

    // Sticky overflow. When a drop and clear_ovf happen in the same cycle,
    // the drop wins.
    always_comb begin
        w_overflow_next = r_overflow;
        if (w_drop) begin
            w_overflow_next = 1'b1;
        end else if (clear_ovf) begin
            w_overflow_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Head register
    // out_data is a registered copy of the entry that will be at the head
    // after this cycle. The next head slot can be the slot being written in
    // this same cycle. That happens when the FIFO was empty, or when it held
    // one entry that is being popped. In that case the new snapshot is
    // forwarded, because the RAM does not hold it yet. When nothing is left,
    // the last value is held. If no pop happens, the next head is the current
    // head, so out_data stays stable while the consumer stalls.
    // ------------------------------------------------------------------------
    always_comb begin
        w_head_next = r_out_data;
        if (w_level_next != '0) begin
            if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
                w_head_next = w_snap;
            end else begin
                w_head_next = r_mem[w_rd_ptr_next];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage
    // The write address is decoded to one-hot enables, one per entry.
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_dec
            assign w_wr_en[gi] = w_push && (r_wr_ptr == ADDR_W'(gi));
        end
    endgenerate

    // Entries are not cleared on reset. Reset moves the pointers, and level
    // tells which entries hold data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_en[i]) begin
                    r_mem[i] <= w_snap;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control and status registers
    // During reset, count may be X. prev_count is forced to zero so that X
    // never reaches the wrap detector.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_count <= '0;
            r_ext        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_prev_count <= count;
            r_ext        <= w_ext_now;
            r_wr_ptr     <= w_wr_ptr_next;
            r_rd_ptr     <= w_rd_ptr_next;
            r_level      <= w_level_next;
            r_out_valid  <= (w_level_next != '0);
            r_out_data   <= w_head_next;
            r_overflow   <= w_overflow_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign level     = r_level;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_count_snapshot_buf.sv
// ============================================================================
// tb_count_snapshot_buf
// Directed bench for count_snapshot_buf with a reference model. When a
// snapshot is accepted, its expected value is pushed to a queue. The head of
// the queue is compared with out_data, and the entry is popped when the
// consumer takes it.
// ============================================================================
module tb_count_snapshot_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] count;
    logic       sample;
    logic       out_ready;
    logic       clear_ovf;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       overflow;

    count_snapshot_buf #(
        .CNT_W (4),
        .EXT_W (4),
        .DEPTH (4),
        .ADDR_W(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .count    (count),
        .sample   (sample),
        .out_ready(out_ready),
        .clear_ovf(clear_ovf),
        .out_valid(out_valid),
        .out_data (out_data),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int         n_err = 0;
    int         n_chk = 0;
    logic [7:0] sb_q[$];
    logic [3:0] m_prev = 4'h0;
    logic [3:0] m_ext  = 4'h0;
    logic       m_ovf  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Drive the inputs, advance the model, then compare the
    // outputs 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic en, input logic [3:0] cnt,
                        input logic smp, input logic rdy, input logic clr);
        logic wrap, gate, pop, push, drop, m_full;
        logic [3:0] ext_now;
        reset     = rst;
        enable    = en;
        count     = cnt;
        sample    = smp;
        out_ready = rdy;
        clear_ovf = clr;
        if (rst) begin
            sb_q.delete();
            m_prev = 4'h0;
            m_ext  = 4'h0;
            m_ovf  = 1'b0;
        end else begin
            wrap = (m_prev == 4'hF) && (cnt == 4'h0);
`ifdef CAPTURE_GATE_EN
            gate = en;
`else
            gate = 1'b1;
`endif
            pop     = (sb_q.size() != 0) && rdy;
            m_full  = (sb_q.size() == 4);
            push    = smp && gate && (!m_full || pop);
            drop    = smp && gate && m_full && !pop;
            ext_now = m_ext + {3'b000, wrap};
            if (pop) void'(sb_q.pop_front());
            if (push) sb_q.push_back({ext_now, cnt});
            m_ext  = ext_now;
            m_prev = cnt;
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
        check("level", 32'(level), 32'(sb_q.size()));
        check("empty", 32'(empty), 32'(sb_q.size() == 0));
        check("full", 32'(full), 32'(sb_q.size() == 4));
        check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (sb_q.size() != 0) check("out_data", 32'(out_data), 32'(sb_q[0]));
        $display("step rst=%0b en=%0b cnt=%h smp=%0b rdy=%0b clr=%0b -> lvl=%0d vld=%0b data=%h ovf=%0b",
                 rst, en, cnt, smp, rdy, clr, level, out_valid, out_data, overflow);
    endtask

    initial begin
        int exp_lvl;

        // Reset with count undriven
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'bxxxx, 1'b0, 1'b0, 1'b0);
        check("rst_out_data", 32'(out_data), 32'h00);

        // First sample after reset
        step(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
        check("t1_data", 32'(out_data), 32'h03);
        // Consumer stalls: head must hold
        step(1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
        check("t1_hold", 32'(out_data), 32'h03);
        step(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);

        // Real wrap, then counter reset (which is not a wrap)
        step(1'b0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
        check("t2_wrap", 32'(out_data), 32'h10);
        step(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
        check("t2_cnt_reset", 32'(out_data), 32'h10);
        step(1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);

        // Fill with out_ready low, then drop on the 5th sample
        for (int i = 2; i <= 6; i++) begin
            step(1'b0, 1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
            if (i == 5) check("t3_full", 32'(full), 32'h1);
            if (i == 6) check("t3_ovf", 32'(overflow), 32'h1);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0);
        check("t3_drained", 32'(empty), 32'h1);
        step(1'b0, 1'b1, 4'h8, 1'b0, 1'b0, 1'b1);
        check("t3_clear", 32'(overflow), 32'h0);

        // Full FIFO with push and pop in the same cycle
        for (int i = 9; i <= 12; i++) step(1'b0, 1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hD, 1'b1, 1'b1, 1'b0);
        check("t4_level", 32'(level), 32'h4);
        check("t4_ovf", 32'(overflow), 32'h0);
        check("t4_head", 32'(out_data), 32'h1A);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'hE, 1'b0, 1'b1, 1'b0);

        // 16 wraps bring ext back to 0
        step(1'b1, 1'b0, 4'bxxxx, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 256; i++) begin
            step(1'b0, 1'b1, 4'(i), (i == 256), 1'b0, 1'b0);
        end
        check("t5_ext_wrap", 32'(out_data), 32'h00);
        step(1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0);

        // Sample while enable is low
        step(1'b0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
`ifdef CAPTURE_GATE_EN
        exp_lvl = 0;
`else
        exp_lvl = 1;
`endif
        check("t6_gate", 32'(level), 32'(exp_lvl));
        while (sb_q.size() < 3) step(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
        check("t6_level3", 32'(level), 32'h3);
        step(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
        check("t6_rst_level", 32'(level), 32'h0);
        check("t6_rst_valid", 32'(out_valid), 32'h0);
        step(1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
